// File: rtl/sc_dot_product_decoder.sv
// Stochastic-stream decoder: counts ones over 2^WIDTH valid samples, rescales by
// DIMENSION and presents each window through a one-entry valid/ready buffer.
module sc_dot_product_decoder #(
   parameter  int WIDTH     = 8,
   parameter  int DIMENSION = 4,
   localparam int OUT_WIDTH = WIDTH + 1 + $clog2(DIMENSION)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 restart,
   input  logic                 in_bit,
   input  logic                 in_valid,
   output logic [OUT_WIDTH-1:0] result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overrun,
   output logic                 busy
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t           state, state_nxt;
   logic [WIDTH:0]   ones_cnt, ones_nxt;
   logic [WIDTH-1:0] sample_cnt, sample_nxt;
   logic             take_p0, done_p0, load_p0;
   logic [WIDTH:0]   final_cnt_p0;

   // Undo the mux adder's 1/DIMENSION scaling at full output width.
   function automatic logic [OUT_WIDTH-1:0] scale(input logic [WIDTH:0] cnt);
      logic [OUT_WIDTH-1:0] wide;
      wide = OUT_WIDTH'(cnt);
      if ((DIMENSION & (DIMENSION - 1)) == 0)
         scale = wide << $clog2(DIMENSION);
      else
         scale = OUT_WIDTH'(wide * DIMENSION);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Stage 0: sample accounting and window completion.
   always_comb begin
      state_nxt    = state;
      ones_nxt     = ones_cnt;
      sample_nxt   = sample_cnt;
      take_p0      = in_valid & ~restart;
      done_p0      = take_p0 & (sample_cnt == '1);
      final_cnt_p0 = ones_cnt + (WIDTH+1)'(in_bit);
      load_p0      = done_p0 & (~out_valid | out_ready);

      if (restart) begin
         ones_nxt   = '0;
         sample_nxt = '0;
      end else if (done_p0) begin
         ones_nxt   = '0;
         sample_nxt = '0;
      end else if (take_p0) begin
         ones_nxt   = final_cnt_p0;
         sample_nxt = sample_cnt + WIDTH'(1);
      end

      case (state)
         IDLE:    if (take_p0 && !done_p0) state_nxt = ACCUM;
         ACCUM:   if (restart || done_p0)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stage 1: counters and the one-entry output buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ones_cnt   <= '0;
         sample_cnt <= '0;
         result     <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         ones_cnt   <= ones_nxt;
         sample_cnt <= sample_nxt;
         if (load_p0) begin
            result    <= scale(final_cnt_p0);
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         // A completed window that cannot be buffered is lost.
         if (done_p0 && !load_p0)
            overrun <= 1'b1;
      end
   end

   assign busy = (state == ACCUM);

endmodule

// File: tb/tb_sc_dot_product_decoder.sv
// Scoreboard bench: two decoders (DIMENSION 4 and 3, WIDTH 4) share one stimulus;
// expected results are queued at issue time and popped on each output handshake.
module tb_sc_dot_product_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       restart = 1'b0;
   logic       in_bit = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [6:0] result4, result3;
   logic       out_valid4, out_valid3, ovf4, ovf3, busy4, busy3;

   int errors = 0;
   int checks = 0;
   int exp4[$];
   int exp3[$];

   always #5 clk = ~clk;

   sc_dot_product_decoder #(.WIDTH(4), .DIMENSION(4)) dut4 (
      .clk(clk), .rst(rst), .restart(restart), .in_bit(in_bit), .in_valid(in_valid),
      .result(result4), .out_valid(out_valid4), .out_ready(out_ready),
      .overrun(ovf4), .busy(busy4));

   sc_dot_product_decoder #(.WIDTH(4), .DIMENSION(3)) dut3 (
      .clk(clk), .rst(rst), .restart(restart), .in_bit(in_bit), .in_valid(in_valid),
      .result(result3), .out_valid(out_valid3), .out_ready(out_ready),
      .overrun(ovf3), .busy(busy3));

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst && out_valid4 && out_ready) begin
         if (exp4.size() == 0) check("dut4 unexpected output", int'(result4), -1);
         else                  check("dut4 result", int'(result4), exp4.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst && out_valid3 && out_ready) begin
         if (exp3.size() == 0) check("dut3 unexpected output", int'(result3), -1);
         else                  check("dut3 result", int'(result3), exp3.pop_front());
      end
   end

   task automatic send(input logic b);
      in_valid = 1'b1;
      in_bit   = b;
      @(posedge clk); #1;
   endtask

   task automatic gap(input int n);
      in_valid = 1'b0;
      in_bit   = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic window(input logic [15:0] bits);
      for (int i = 0; i < 16; i++) send(bits[i]);
   endtask

   task automatic wait_drained(input string name);
      for (int i = 0; i < 20 && (exp4.size() != 0 || exp3.size() != 0); i++) begin
         @(posedge clk); #1;
      end
      check(name, exp4.size() + exp3.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL global timeout: got running, required finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] pat;
      pat = 16'h1249;

      repeat (2) @(posedge clk);
      #1;
      check("reset result", int'(result4), 0);
      check("reset out_valid", int'(out_valid4), 0);
      check("reset overrun", int'(ovf4), 0);
      check("reset busy", int'(busy4), 0);
      rst = 1'b1;
      gap(1);

      // all ones, consumer always ready
      out_ready = 1'b1;
      exp4.push_back(64); exp3.push_back(48);
      for (int i = 0; i < 15; i++) send(1'b1);
      check("valid before last sample", int'(out_valid4), 0);
      check("busy mid window", int'(busy4), 1);
      send(1'b1);
      check("latency one cycle", int'(out_valid4), 1);
      gap(2);
      wait_drained("all ones drained");
      check("no overrun", int'(ovf4), 0);

      // alternating bits with a 3-cycle gap mid-window
      exp4.push_back(32); exp3.push_back(24);
      for (int i = 0; i < 16; i++) begin
         send((i % 2) == 0);
         if (i == 7) gap(3);
      end
      gap(2);
      wait_drained("alternating drained");

      // five ones in sixteen samples
      exp4.push_back(20); exp3.push_back(15);
      window(pat);
      gap(2);
      wait_drained("five ones drained");

      // restart on sample 7 discards earlier samples
      exp4.push_back(64); exp3.push_back(48);
      for (int i = 0; i < 6; i++) send(1'b0);
      restart = 1'b1;
      send(1'b1);
      restart = 1'b0;
      check("restart clears busy", int'(busy4), 0);
      gap(1);
      for (int i = 0; i < 16; i++) send(1'b1);
      gap(2);
      wait_drained("restart drained");

      // back-to-back windows with consumer stalled
      out_ready = 1'b0;
      exp4.push_back(64); exp3.push_back(48);
      window(16'hFFFF);
      window(16'h0000);
      gap(2);
      check("overrun dut4", int'(ovf4), 1);
      check("overrun dut3", int'(ovf3), 1);
      check("held valid", int'(out_valid4), 1);
      check("held result", int'(result4), 64);
      out_ready = 1'b1;
      gap(1);
      check("valid after drain", int'(out_valid4), 0);
      wait_drained("overrun drained");

      // asynchronous reset mid-window
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(1'b1);
      check("busy before reset", int'(busy4), 1);
      #2 rst = 1'b0;
      #1;
      check("async reset result", int'(result4), 0);
      check("async reset overrun", int'(ovf4), 0);
      check("async reset busy", int'(busy4), 0);
      check("async reset out_valid", int'(out_valid4), 0);
      exp4.delete(); exp3.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      gap(1);

      // ready rises exactly on window 2 completion edge
      exp4.push_back(64); exp3.push_back(48);
      exp4.push_back(20); exp3.push_back(15);
      window(16'hFFFF);
      for (int i = 0; i < 15; i++) send(pat[i]);
      out_ready = 1'b1;
      send(pat[15]);
      check("window 2 loaded", int'(out_valid4), 1);
      gap(2);
      wait_drained("simultaneous drained");
      check("no overrun on same-edge drain", int'(ovf4), 0);
      check("no overrun dut3", int'(ovf3), 0);
      check("final valid", int'(out_valid4), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
